btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Input-side companion to the board LED/button logic: takes the five raw push-buttons and eight slide switches straight from the pads and delivers clean, synchronous signals to the downstream counter/display logic. It performs:
- 2-flop synchronisation of every input.
- Per-button debouncing.
- Single-cycle press/release strobes.
- An optional hold-to-auto-repeat strobe.

Downstream logic consumes only these outputs, never the raw pins.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples required to accept a button change (>=2).
- HOLD_CYCLES, 50000000: cycles a button must stay pressed before the first auto-repeat strobe (>=2).
- REPEAT_CYCLES, 10000000: cycles between subsequent auto-repeat strobes (>=2).
- REPEAT_EN, 1: 1 enables auto-repeat; 0 forces btn_repeat to 0 and keeps every FSM in IDLE.

Ports:
- clk  in  1  system clock; all flops rise on posedge clk.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  5  raw pads, bit order {ctr, rt, lft, dwn, up}; 1 = pressed.
- sw_raw  in  8  raw slide switches.
- btn_level  out  5  debounced button level.
- btn_press  out  5  one-cycle strobe when btn_level rises.
- btn_release  out  5  one-cycle strobe when btn_level falls.
- btn_repeat  out  5  one-cycle auto-repeat strobe.
- btn_event  out  5  btn_press | btn_repeat.
- sw_sync  out  8  switches after the 2-flop synchroniser (not debounced).

## Operation
- **Synchroniser:** two flops per bit, s1 <= raw and s2 <= s1, for all 13 inputs. sw_sync = s2 of sw_raw.
- **Debouncer (per button, independent):**
  - Uses counter cnt, width clog2(DEBOUNCE_CYCLES).
  - Each edge with s2 == btn_level: cnt <= 0.
  - Each edge with s2 != btn_level:
    - if cnt == DEBOUNCE_CYCLES-1: btn_level <= s2, cnt <= 0;
    - else cnt <= cnt+1.
  - Any sample matching btn_level restarts the count, so a glitch shorter than DEBOUNCE_CYCLES never changes btn_level.
- **Strobes:** btn_press and btn_release are registered and assert in the same cycle btn_level changes. Each is high for exactly one cycle per accepted transition.
- **Repeat FSM (per button):** states IDLE, HOLD, REPEAT, with a timer wide enough for max(HOLD_CYCLES, REPEAT_CYCLES).
  - IDLE: on a press commit -> HOLD, timer <= 0.
  - HOLD:
    - if timer == HOLD_CYCLES-1: btn_repeat pulse, -> REPEAT, timer <= 0;
    - else timer++.
  - REPEAT:
    - if timer == REPEAT_CYCLES-1: btn_repeat pulse, timer <= 0;
    - else timer++.
  - Release commit, from any state: -> IDLE, timer <= 0, with no repeat pulse in that cycle. Release has priority over a coincident timer expiry.
- **btn_event:** registered OR of the press and repeat conditions, aligned with both strobes.
- **Independence:** buttons are fully independent. Simultaneous presses, releases or repeats on several bits all assert in the same cycle.

## Timing
- **Reset:** all outputs 0; all synchroniser flops 0; cnt and timer 0; every FSM in IDLE. Reset mid-debounce or mid-repeat discards the progress.
- **Debounce latency:** a raw change that stays stable is first captured by s1 at edge 1. btn_level and the matching strobe update at edge DEBOUNCE_CYCLES+2.
- **Repeat timing:** for a press committed at edge P, repeat strobes occur at edges P+HOLD_CYCLES, then P+HOLD_CYCLES+k*REPEAT_CYCLES for k = 1, 2, … while held.
- **sw_sync latency:** 2 cycles.
- **Button held through reset:** after rst deasserts, btn_level starts at 0. The button debounces normally and btn_press fires DEBOUNCE_CYCLES+2 edges after release of reset. No strobe occurs during reset.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, REPEAT_EN=1.
- **Clean press/release:** set up to 1 for 20 cycles, then 0.
  - btn_level[0] rises at edge 6 with btn_press[0] and btn_event[0] high for one cycle.
  - After release, btn_level[0] falls 6 edges later with btn_release[0] for one cycle.
- **Bounce:** toggle btn_raw[4] in the pattern 1,0,1,1,0,1,1,1,0, then hold 1.
  - No output changes during the bouncing.
  - btn_level[4] rises exactly 6 edges after the final stable 1 appears.
- **Auto-repeat:** hold lft with its press committed at edge P.
  - btn_repeat[2] pulses at P+10, P+13, P+16.
  - A release committed at P+19 (coinciding with a timer expiry) produces no repeat at P+19 and returns the FSM to IDLE.
- **Simultaneous buttons:** press up and ctr on the same cycle.
  - Both btn_press bits assert in the same cycle.
  - Releasing only up leaves ctr repeating on schedule.
- **Reset mid-operation:** assert rst for 1 cycle during REPEAT while dwn is held.
  - All outputs are 0 in the cycle after reset.
  - btn_press[1] fires again 6 edges after rst deasserts.
- **Switches and REPEAT_EN=0:** sw_raw = 8'hA5 appears on sw_sync after 2 cycles. With REPEAT_EN=0, a 30-cycle hold gives btn_press only and btn_repeat stays 0.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and strobe five push-buttons; synchronise eight switches
//   clk, rst     : system clock, synchronous active-high reset
//   btn_raw[4:0] : raw button pads {ctr, rt, lft, dwn, up}, 1 = pressed
//   sw_raw[7:0]  : raw slide switches
//   btn_level    : debounced button level
//   btn_press    : one-cycle strobe on accepted rising level
//   btn_release  : one-cycle strobe on accepted falling level
//   btn_repeat   : one-cycle hold-to-auto-repeat strobe
//   btn_event    : btn_press | btn_repeat
//   sw_sync      : 2-flop synchronised switches
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    input  logic [7:0] sw_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic [4:0] btn_repeat,
    output logic [4:0] btn_event,
    output logic [7:0] sw_sync
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int TMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HMAX = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] RMAX = TW'(REPEAT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    logic [4:0] b1, b2;
    logic [7:0] w1;
    always_ff @(posedge clk) begin
        if (rst) begin
            b1      <= '0;
            b2      <= '0;
            w1      <= '0;
            sw_sync <= '0;
        end else begin
            b1      <= btn_raw;
            b2      <= b1;
            w1      <= sw_raw;
            sw_sync <= w1;
        end
    end
    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic [CW-1:0] cnt;
        logic [TW-1:0] tmr;
        state_t st;
        logic lvl, prs, rel, rpt, evt;
        logic commit, rise, fall, expire, rep;
        // a change is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching sample
        assign commit = (b2[i] != lvl) && (cnt == CMAX);
        assign rise   = commit && b2[i];
        assign fall   = commit && !b2[i];
        assign expire = (st == HOLD && tmr == HMAX) || (st == REPEAT && tmr == RMAX);
        // a coincident release suppresses the repeat pulse
        assign rep    = (REPEAT_EN != 0) && expire && !fall;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                tmr <= '0;
                st  <= IDLE;
                lvl <= 1'b0;
                prs <= 1'b0;
                rel <= 1'b0;
                rpt <= 1'b0;
                evt <= 1'b0;
            end else begin
                cnt <= (b2[i] == lvl || commit) ? '0 : cnt + 1'b1;
                lvl <= commit ? b2[i] : lvl;
                prs <= rise;
                rel <= fall;
                rpt <= rep;
                evt <= rise | rep;
                if (REPEAT_EN == 0 || fall) begin
                    st  <= IDLE;
                    tmr <= '0;
                end else if (rise) begin
                    st  <= HOLD;
                    tmr <= '0;
                end else if (expire) begin
                    st  <= REPEAT;
                    tmr <= '0;
                end else if (st != IDLE) begin
                    tmr <= tmr + 1'b1;
                end
            end
        end
        assign btn_level[i]   = lvl;
        assign btn_press[i]   = prs;
        assign btn_release[i] = rel;
        assign btn_repeat[i]  = rpt;
        assign btn_event[i]   = evt;
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of btn_conditioner with DEBOUNCE=4, HOLD=10, REPEAT=3
module tb_btn_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] nr_raw = '0;
    logic [7:0] sw_raw = '0;
    logic [4:0] btn_level, btn_press, btn_release, btn_repeat, btn_event;
    logic [7:0] sw_sync;
    logic [4:0] n_level, n_press, n_release, n_repeat, n_event;
    logic [7:0] n_sw;
    logic [0:8] bounce = 9'b101101110;
    logic [7:0] want;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .btn_event(btn_event), .sw_sync(sw_sync)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(0)
    ) dut_norep (
        .clk(clk), .rst(rst), .btn_raw(nr_raw), .sw_raw(sw_raw),
        .btn_level(n_level), .btn_press(n_press), .btn_release(n_release),
        .btn_repeat(n_repeat), .btn_event(n_event), .sw_sync(n_sw)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(2);
        chk("rst_level", 8'(btn_level), 8'h00);
        chk("rst_strobes", 8'(btn_press | btn_release | btn_repeat | btn_event), 8'h00);
        chk("rst_sw", sw_sync, 8'h00);
        rst = 1'b0;

        btn_raw = 5'b00001;
        tick(5);
        chk("up_level_e5", 8'(btn_level), 8'h00);
        chk("up_press_e5", 8'(btn_press), 8'h00);
        tick();
        chk("up_level_e6", 8'(btn_level), 8'h01);
        chk("up_press_e6", 8'(btn_press), 8'h01);
        chk("up_event_e6", 8'(btn_event), 8'h01);
        tick();
        chk("up_press_e7", 8'(btn_press), 8'h00);
        chk("up_event_e7", 8'(btn_event), 8'h00);
        tick(13);
        btn_raw = 5'b00000;
        tick(5);
        chk("up_rel_level_5", 8'(btn_level), 8'h01);
        chk("up_rel_strobe_5", 8'(btn_release), 8'h00);
        tick();
        chk("up_rel_level_6", 8'(btn_level), 8'h00);
        chk("up_rel_strobe_6", 8'(btn_release), 8'h01);
        tick();
        chk("up_rel_strobe_7", 8'(btn_release), 8'h00);
        tick(4);

        for (int k = 0; k < 9; k++) begin
            btn_raw[4] = bounce[k];
            tick();
            chk("bounce_quiet", 8'(btn_level | btn_press | btn_release), 8'h00);
        end
        btn_raw[4] = 1'b1;
        tick(5);
        chk("bounce_level_5", 8'(btn_level), 8'h00);
        tick();
        chk("bounce_level_6", 8'(btn_level), 8'h10);
        chk("bounce_press_6", 8'(btn_press), 8'h10);
        btn_raw = 5'b00000;
        tick(6);
        chk("bounce_release", 8'(btn_release), 8'h10);
        tick(3);

        btn_raw = 5'b00100;
        tick(6);
        chk("lft_press", 8'(btn_press), 8'h04);
        for (int t = 1; t <= 24; t++) begin
            if (t == 14) btn_raw = 5'b00000;
            tick();
            want = (t == 10 || t == 13 || t == 16) ? 8'h04 : 8'h00;
            chk("lft_repeat", 8'(btn_repeat), want);
            chk("lft_event", 8'(btn_event), want);
            if (t == 18) chk("lft_level_p18", 8'(btn_level), 8'h04);
            if (t == 19) begin
                chk("lft_level_p19", 8'(btn_level), 8'h00);
                chk("lft_release_p19", 8'(btn_release), 8'h04);
            end
        end

        btn_raw = 5'b10001;
        tick(6);
        chk("simul_press", 8'(btn_press), 8'h11);
        chk("simul_event", 8'(btn_event), 8'h11);
        btn_raw = 5'b10000;
        for (int t = 1; t <= 20; t++) begin
            tick();
            want = (t == 10 || t == 13 || t == 16 || t == 19) ? 8'h10 : 8'h00;
            chk("ctr_repeat", 8'(btn_repeat), want);
            if (t == 6) begin
                chk("up_only_release", 8'(btn_release), 8'h01);
                chk("ctr_still_level", 8'(btn_level), 8'h10);
            end
        end
        btn_raw = 5'b00000;
        tick(8);
        chk("simul_idle", 8'(btn_level), 8'h00);

        btn_raw = 5'b00010;
        tick(6);
        chk("dwn_press", 8'(btn_press), 8'h02);
        tick(12);
        rst = 1'b1;
        tick();
        chk("midrst_outputs", 8'(btn_level | btn_press | btn_release | btn_repeat | btn_event), 8'h00);
        rst = 1'b0;
        tick(5);
        chk("midrst_level_5", 8'(btn_level), 8'h00);
        tick();
        chk("midrst_press_6", 8'(btn_press), 8'h02);
        tick(9);
        chk("midrst_rep_9", 8'(btn_repeat), 8'h00);
        tick();
        chk("midrst_rep_10", 8'(btn_repeat), 8'h02);
        btn_raw = 5'b00000;
        tick(8);

        sw_raw = 8'hA5;
        tick();
        chk("sw_lat1", sw_sync, 8'h00);
        tick();
        chk("sw_lat2", sw_sync, 8'hA5);

        nr_raw = 5'b01000;
        for (int t = 1; t <= 30; t++) begin
            tick();
            want = (t == 6) ? 8'h08 : 8'h00;
            chk("norep_press", 8'(n_press), want);
            chk("norep_event", 8'(n_event), want);
            chk("norep_repeat", 8'(n_repeat), 8'h00);
        end
        chk("norep_level", 8'(n_level), 8'h08);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
